// File: rtl/wb_regfile_if.sv
// wb_regfile_if: writeback, decode read-port and commit-status signals of wb_regfile.
// The pipeline side uses the master modport; the register file uses the slave modport.
interface wb_regfile_if;
   logic        op_reg_write_wb;
   logic        op_reg_write_address_wb;
   logic        op_res_wb;
   logic [2:0]  rs_wb;
   logic [2:0]  rd_wb;
   logic [15:0] data_register_wb;
   logic [15:0] memory_data_register_wb;
   logic [2:0]  read_addr_a;
   logic [2:0]  read_addr_b;
   logic [15:0] read_data_a;
   logic [15:0] read_data_b;
   logic        wb_commit;
   logic [2:0]  wb_commit_addr;
   logic [15:0] wb_commit_data;
   logic [15:0] retire_count;

   modport master (
      output op_reg_write_wb, op_reg_write_address_wb, op_res_wb,
      output rs_wb, rd_wb, data_register_wb, memory_data_register_wb,
      output read_addr_a, read_addr_b,
      input  read_data_a, read_data_b,
      input  wb_commit, wb_commit_addr, wb_commit_data, retire_count
   );

   modport slave (
      input  op_reg_write_wb, op_reg_write_address_wb, op_res_wb,
      input  rs_wb, rd_wb, data_register_wb, memory_data_register_wb,
      input  read_addr_a, read_addr_b,
      output read_data_a, read_data_b,
      output wb_commit, wb_commit_addr, wb_commit_data, retire_count
   );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: 8 x 16-bit register file with two combinational read ports and commit status.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module wb_regfile (
   input  logic        clock,
   input  logic        reset,
   wb_regfile_if.slave bus
);

   logic [15:0] regs [8];
   logic [15:0] wb_data;
   logic [2:0]  wb_addr;

   logic        commit_q;
   logic [2:0]  commit_addr_q;
   logic [15:0] commit_data_q;
   logic [15:0] retire_q;

   always_comb begin
      wb_data = bus.op_res_wb ? bus.memory_data_register_wb : bus.data_register_wb;
      wb_addr = bus.op_reg_write_address_wb ? bus.rs_wb : bus.rd_wb;
   end

   // NOTE: every register is cleared by reset, so the array maps to flops, not a RAM macro.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            regs[i] <= 16'h0000;
         end
         commit_q      <= 1'b0;
         commit_addr_q <= 3'b000;
         commit_data_q <= 16'h0000;
         retire_q      <= 16'h0000;
      end else begin
         commit_q <= bus.op_reg_write_wb;
         if (bus.op_reg_write_wb) begin
            regs[wb_addr] <= wb_data;
            commit_addr_q <= wb_addr;
            commit_data_q <= wb_data;
            retire_q      <= retire_q + 16'd1;
         end
      end
   end

`ifdef WB_REGFILE_BYPASS_EN
   logic fwd_a;
   logic fwd_b;

   always_comb begin
      fwd_a = bus.op_reg_write_wb && !reset && (bus.read_addr_a == wb_addr);
      fwd_b = bus.op_reg_write_wb && !reset && (bus.read_addr_b == wb_addr);
      bus.read_data_a = fwd_a ? wb_data : regs[bus.read_addr_a];
      bus.read_data_b = fwd_b ? wb_data : regs[bus.read_addr_b];
   end
`else
   always_comb begin
      bus.read_data_a = regs[bus.read_addr_a];
      bus.read_data_b = regs[bus.read_addr_b];
   end
`endif

   assign bus.wb_commit      = commit_q;
   assign bus.wb_commit_addr = commit_addr_q;
   assign bus.wb_commit_data = commit_data_q;
   assign bus.retire_count   = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and random checks of wb_regfile against an array-based reference model.
// Build with WB_REGFILE_BYPASS_EN defined to check the forwarding variant.
module tb_wb_regfile;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   wb_regfile_if bus ();

   wb_regfile dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] m_regs [8];
   logic        m_commit;
   logic [2:0]  m_caddr;
   logic [15:0] m_cdata;
   logic [15:0] m_count;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] cur_addr();
      return bus.op_reg_write_address_wb ? bus.rs_wb : bus.rd_wb;
   endfunction

   function automatic logic [15:0] cur_data();
      return bus.op_res_wb ? bus.memory_data_register_wb : bus.data_register_wb;
   endfunction

   // What a read port should show right now, given the pending writeback inputs.
   function automatic logic [15:0] exp_read(input logic [2:0] addr);
`ifdef WB_REGFILE_BYPASS_EN
      if (bus.op_reg_write_wb && !reset && addr == cur_addr()) return cur_data();
`endif
      return m_regs[addr];
   endfunction

   task automatic drive(input logic we, input logic asel, input logic res,
                        input logic [2:0] rs, input logic [2:0] rd,
                        input logic [15:0] dreg, input logic [15:0] dmem);
      bus.op_reg_write_wb         = we;
      bus.op_reg_write_address_wb = asel;
      bus.op_res_wb               = res;
      bus.rs_wb                   = rs;
      bus.rd_wb                   = rd;
      bus.data_register_wb        = dreg;
      bus.memory_data_register_wb = dmem;
   endtask

   task automatic drive_random(input logic we);
      drive(we, 1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
            16'($urandom), 16'($urandom));
   endtask

   // Advance one clock edge and apply the same edge to the reference model.
   task automatic step();
      @(posedge clock);
      if (reset) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
         m_commit = 1'b0;
         m_caddr  = 3'b000;
         m_cdata  = 16'h0000;
         m_count  = 16'h0000;
      end else begin
         m_commit = bus.op_reg_write_wb;
         if (bus.op_reg_write_wb) begin
            m_regs[cur_addr()] = cur_data();
            m_caddr = cur_addr();
            m_cdata = cur_data();
            m_count = m_count + 16'd1;
         end
      end
      #1;
   endtask

   task automatic check_status(input string tag);
      check({tag, ".commit"}, 16'(bus.wb_commit), 16'(m_commit));
      check({tag, ".commit_addr"}, 16'(bus.wb_commit_addr), 16'(m_caddr));
      check({tag, ".commit_data"}, bus.wb_commit_data, m_cdata);
      check({tag, ".retire_count"}, bus.retire_count, m_count);
   endtask

   // Sweeps both read ports over all registers; fits inside one clock period.
   task automatic check_all_regs(input string tag);
      for (int i = 0; i < 8; i++) begin
         bus.read_addr_a = 3'(i);
         bus.read_addr_b = 3'(7 - i);
         #1;
         check($sformatf("%s.a[%0d]", tag, i), bus.read_data_a, exp_read(3'(i)));
         check($sformatf("%s.b[%0d]", tag, 7 - i), bus.read_data_b, exp_read(3'(7 - i)));
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'hxxxx;
      bus.read_addr_a = 3'd0;
      bus.read_addr_b = 3'd0;

      // Reset with a write pending: reset must win.
      reset = 1'b1;
      drive_random(1'b1);
      step();
      step();
      check_status("reset");
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000);
      check_all_regs("reset_regs");

      // ALU writeback to rd=3.
      drive(1'b1, 1'b0, 1'b0, 3'd6, 3'd3, 16'h1234, 16'h9999);
      step();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000);
      bus.read_addr_a = 3'd3;
      #1;
      check("alu_write.r3", bus.read_data_a, 16'h1234);
      check("alu_write.commit", 16'(bus.wb_commit), 16'h0001);
      check("alu_write.commit_addr", 16'(bus.wb_commit_addr), 16'h0003);
      check("alu_write.retire_count", bus.retire_count, 16'h0001);

      // Load writeback routed to rs=5; rd=2 must stay untouched.
      drive(1'b1, 1'b1, 1'b1, 3'd5, 3'd2, 16'h0001, 16'hBEEF);
      step();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000);
      bus.read_addr_a = 3'd5;
      bus.read_addr_b = 3'd2;
      #1;
      check("load_write.r5", bus.read_data_a, 16'hBEEF);
      check("load_write.r2", bus.read_data_b, 16'h0000);
      check_status("load_write");

      // Same-cycle write and read of r4.
      drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 16'hA5A5, 16'h0000);
      bus.read_addr_b = 3'd4;
      #1;
`ifdef WB_REGFILE_BYPASS_EN
      check("same_cycle.r4", bus.read_data_b, 16'hA5A5);
`else
      check("same_cycle.r4", bus.read_data_b, 16'h0000);
`endif
      step();
      drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000);
      #1;
      check("after_write.r4", bus.read_data_b, 16'hA5A5);

      // Both ports on the same register.
      bus.read_addr_a = 3'd5;
      bus.read_addr_b = 3'd5;
      #1;
      check("same_addr.a", bus.read_data_a, 16'hBEEF);
      check("same_addr.b", bus.read_data_b, 16'hBEEF);

      // Random traffic: reads checked before each edge, status after it.
      for (int n = 0; n < 300; n++) begin
         drive_random(($urandom_range(0, 3) != 0));
         bus.read_addr_a = 3'($urandom);
         bus.read_addr_b = (n % 7 == 0) ? bus.read_addr_a : 3'($urandom);
         #1;
         check($sformatf("rand%0d.a", n), bus.read_data_a, exp_read(bus.read_addr_a));
         check($sformatf("rand%0d.b", n), bus.read_data_b, exp_read(bus.read_addr_b));
         step();
         check_status($sformatf("rand%0d", n));
      end

      // Idle for 10 cycles with changing data: nothing may move.
      for (int n = 0; n < 10; n++) begin
         drive_random(1'b0);
         step();
         check_status($sformatf("idle%0d", n));
         check($sformatf("idle%0d.commit_low", n), 16'(bus.wb_commit), 16'h0000);
      end
      drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000);
      check_all_regs("idle_regs");

      // Run the retire counter up to 0xFFFF, then one more write must wrap it.
      while (m_count != 16'hFFFF) begin
         drive_random(1'b1);
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000);
      check("count_max", bus.retire_count, 16'hFFFF);
      drive(1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 16'h5A5A, 16'h0000);
      step();
      check("count_wrap", bus.retire_count, 16'h0000);
      check_status("wrap");

      // Reset together with a write to r7: r7 clears, no commit, count clears.
      drive(1'b1, 1'b0, 1'b1, 3'd0, 3'd7, 16'h0000, 16'hFFFF);
      reset = 1'b1;
      bus.read_addr_a = 3'd7;
      #1;
      check("reset_write.r7_during", bus.read_data_a, 16'h5A5A);
      step();
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000);
      #1;
      check("reset_write.r7", bus.read_data_a, 16'h0000);
      check("reset_write.commit", 16'(bus.wb_commit), 16'h0000);
      check("reset_write.retire_count", bus.retire_count, 16'h0000);
      check_status("reset_write");
      check_all_regs("post_reset_regs");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
